// File: rtl/memory_access_unit_pkg.sv
// rtl/memory_access_unit_pkg.sv - shared types, size/sign codes and trap causes for memory_access_unit
package memory_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // func3[1:0] selects the access size, func3[2] selects zero-extension
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;
    localparam int F3_UNSIGNED_BIT = 2;

    localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;

    // Address bits that must be zero for a naturally aligned access (sz-1)
    function automatic logic [2:0] size_low_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    // One bit per byte touched by the access, before lane shifting
    function automatic logic [7:0] size_byte_mask(input logic [1:0] sz);
        case (sz)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0F;
            default: return 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - combinational load lane shift, truncate and sign/zero extend
// rdata_i: 64-bit aligned cache word; off_i: byte offset; func3_i: size/sign; data_o: writeback value
module load_align_ext
    import memory_access_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [2:0]            off_i,
    input  logic [2:0]            func3_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;
    logic                  sign_ext;

    always_comb begin
        shifted  = rdata_i >> {off_i, 3'b000};
        sign_ext = ~func3_i[F3_UNSIGNED_BIT];
        data_o   = shifted;
        case (func3_i[1:0])
            SZ_B: data_o = {{(DATA_WIDTH-8){sign_ext & shifted[7]}},  shifted[7:0]};
            SZ_H: data_o = {{(DATA_WIDTH-16){sign_ext & shifted[15]}}, shifted[15:0]};
            SZ_W: data_o = {{(DATA_WIDTH-32){sign_ext & shifted[31]}}, shifted[31:0]};
            SZ_D: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - memory-stage load/store engine with cache handshake (option: MISALIGN_TRAP_EN)
// Pipeline in: valid_i, mem_access_i, mem_we_i, alu_result_i, write_data_i, func3_i, flush_i; out: stall_mem_o
// Cache: dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_wstrb_o, dc_ready_i, dc_rvalid_i, dc_rdata_i
// Writeback: read_data_o, read_valid_o; trap: misaligned_o, cause_o
module memory_access_unit
    import memory_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    valid_i,
    input  logic                    mem_access_i,
    input  logic                    mem_we_i,
    input  logic [ADDR_WIDTH-1:0]   alu_result_i,
    input  logic [DATA_WIDTH-1:0]   write_data_i,
    input  logic [2:0]              func3_i,
    input  logic                    flush_i,
    output logic                    dc_req_o,
    output logic                    dc_we_o,
    output logic [ADDR_WIDTH-1:0]   dc_addr_o,
    output logic [DATA_WIDTH-1:0]   dc_wdata_o,
    output logic [DATA_WIDTH/8-1:0] dc_wstrb_o,
    input  logic                    dc_ready_i,
    input  logic                    dc_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   dc_rdata_i,
    output logic                    stall_mem_o,
    output logic [DATA_WIDTH-1:0]   read_data_o,
    output logic                    read_valid_o,
    output logic                    misaligned_o,
    output logic [3:0]              cause_o
);

    localparam int STRB_W = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-4:0]   req_addr_q;
    logic [DATA_WIDTH-1:0]   req_wdata_q;
    logic [STRB_W-1:0]       req_wstrb_q;
    logic                    req_we_q;
    logic [2:0]              req_func3_q;
    logic [2:0]              req_off_q;
    logic                    kill_q;
    logic                    trap_q;
    logic [DATA_WIDTH-1:0]   read_data_q;

    logic                    new_access;
    logic                    take_trap;
    logic [2:0]              low_mask;
    logic [2:0]              new_off;
    logic [STRB_W-1:0]       byte_mask_w;
    logic [STRB_W-1:0]       new_strb;
    logic [DATA_WIDTH-1:0]   data_mask;
    logic [DATA_WIDTH-1:0]   new_wdata;
    logic [DATA_WIDTH-1:0]   ext_data;

    assign new_access  = valid_i & mem_access_i & ~flush_i;
    assign low_mask    = size_low_mask(func3_i[1:0]);
    assign byte_mask_w = STRB_W'(size_byte_mask(func3_i[1:0]));

`ifdef MISALIGN_TRAP_EN
    assign take_trap = |(alu_result_i[2:0] & low_mask);
    assign new_off   = alu_result_i[2:0];
`else
    // Misaligned addresses are silently rounded down to the natural boundary
    assign take_trap = 1'b0;
    assign new_off   = alu_result_i[2:0] & ~low_mask;
`endif

    // Store data is masked to the access size before lane shifting so stale upper bits never reach the cache
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < STRB_W; i++) begin
            data_mask[8*i +: 8] = {8{byte_mask_w[i]}};
        end
        new_strb  = byte_mask_w << new_off;
        new_wdata = (write_data_i & data_mask) << {new_off, 3'b000};
    end

    load_align_ext #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align_ext (
        .rdata_i (dc_rdata_i),
        .off_i   (req_off_q),
        .func3_i (req_func3_q),
        .data_o  (ext_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (new_access) state_d = take_trap ? DONE : REQ;
            REQ: begin
                if (dc_ready_i) begin
                    state_d = (req_we_q || dc_rvalid_i) ? DONE : WAIT;
                end else if (flush_i) begin
                    state_d = IDLE;
                end
            end
            WAIT: if (dc_rvalid_i) state_d = DONE;
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            req_we_q    <= 1'b0;
            req_func3_q <= 3'd0;
            req_off_q   <= 3'd0;
            kill_q      <= 1'b0;
            trap_q      <= 1'b0;
            read_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (new_access) begin
                        req_addr_q  <= alu_result_i[ADDR_WIDTH-1:3];
                        req_wdata_q <= new_wdata;
                        req_wstrb_q <= new_strb;
                        req_we_q    <= mem_we_i;
                        req_func3_q <= func3_i;
                        req_off_q   <= new_off;
                        kill_q      <= 1'b0;
                        trap_q      <= take_trap;
                    end
                end
                REQ: begin
                    // A flush coinciding with acceptance cannot recall the request; it only kills the result
                    if (dc_ready_i) begin
                        kill_q <= flush_i;
                        if (!req_we_q && dc_rvalid_i && !flush_i) read_data_q <= ext_data;
                    end
                end
                WAIT: begin
                    if (flush_i) kill_q <= 1'b1;
                    if (dc_rvalid_i && !kill_q && !flush_i) read_data_q <= ext_data;
                end
                default: ;
            endcase
        end
    end

    assign stall_mem_o  = ~rst_i & (((state_q == IDLE) & new_access) | (state_q == REQ) | (state_q == WAIT));
    assign dc_req_o     = ~rst_i & (state_q == REQ);
    assign read_valid_o = ~rst_i & (state_q == DONE) & ~req_we_q & ~kill_q & ~trap_q;
    assign dc_we_o      = req_we_q;
    assign dc_addr_o    = {req_addr_q, 3'b000};
    assign dc_wdata_o   = req_wdata_q;
    assign dc_wstrb_o   = req_wstrb_q;
    assign read_data_o  = read_data_q;

`ifdef MISALIGN_TRAP_EN
    assign misaligned_o = ~rst_i & (state_q == DONE) & trap_q;
    assign cause_o      = misaligned_o ? (req_we_q ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN) : 4'd0;
`else
    assign misaligned_o = 1'b0;
    assign cause_o      = 4'd0;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - self-checking scoreboard bench for memory_access_unit
module tb_memory_access_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0, mem_access_i = 1'b0, mem_we_i = 1'b0, flush_i = 1'b0;
    logic [63:0] alu_result_i = '0, write_data_i = '0, dc_rdata_i = '0;
    logic [2:0]  func3_i = '0;
    logic        dc_ready_i = 1'b0, dc_rvalid_i = 1'b0;
    logic        dc_req_o, dc_we_o, stall_mem_o, read_valid_o, misaligned_o;
    logic [63:0] dc_addr_o, dc_wdata_o, read_data_o;
    logic [7:0]  dc_wstrb_o;
    logic [3:0]  cause_o;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        rvalid;
        logic [63:0] rdata;
        int          stalls;
        int          reqs;
        logic        mis;
        logic [3:0]  cause;
        logic        timeout;
    } rec_t;

    rec_t exp_q[$];

    memory_access_unit dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_access_i(mem_access_i),
        .mem_we_i(mem_we_i), .alu_result_i(alu_result_i), .write_data_i(write_data_i),
        .func3_i(func3_i), .flush_i(flush_i), .dc_req_o(dc_req_o), .dc_we_o(dc_we_o),
        .dc_addr_o(dc_addr_o), .dc_wdata_o(dc_wdata_o), .dc_wstrb_o(dc_wstrb_o),
        .dc_ready_i(dc_ready_i), .dc_rvalid_i(dc_rvalid_i), .dc_rdata_i(dc_rdata_i),
        .stall_mem_o(stall_mem_o), .read_data_o(read_data_o), .read_valid_o(read_valid_o),
        .misaligned_o(misaligned_o), .cause_o(cause_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic [63:0] align_addr(input logic [63:0] addr, input logic [2:0] f3);
        logic [63:0] m;
        m = 64'(size_of(f3) - 1);
`ifdef MISALIGN_TRAP_EN
        return addr;
`else
        return addr & ~m;
`endif
    endfunction

    function automatic rec_t model_req(input logic we, input logic [63:0] addr,
                                       input logic [63:0] data, input logic [2:0] f3);
        rec_t r;
        logic [63:0] eff;
        int o;
        r = '{default: 0};
        eff = align_addr(addr, f3);
        o = int'(eff[2:0]);
        for (int b = 0; b < size_of(f3); b++) begin
            r.wstrb[o + b] = 1'b1;
            if (we) r.wdata[8*(o + b) +: 8] = data[8*b +: 8];
        end
        r.addr = {eff[63:3], 3'b000};
        r.we = we;
        return r;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] addr, input logic [63:0] rdata,
                                               input logic [2:0] f3);
        logic [63:0] v;
        logic [63:0] eff;
        int o, sz;
        eff = align_addr(addr, f3);
        o = int'(eff[2:0]);
        sz = size_of(f3);
        v = '0;
        for (int b = 0; b < sz; b++) v[8*b +: 8] = rdata[8*(o + b) +: 8];
        if (!f3[2] && sz < 8 && v[8*sz - 1]) begin
            for (int k = 8*sz; k < 64; k++) v[k] = 1'b1;
        end
        return v;
    endfunction

    // Drives one instruction and plays the cache; rdy_dly = REQ cycles before ready,
    // lat = cycles from accept to rvalid (0 = same cycle), flush_cyc = cycle index to flush (-1 none)
    task automatic do_access(input logic mem, input logic we, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [2:0] f3, input logic [63:0] resp,
                             input int rdy_dly, input int lat, input int flush_cyc, output rec_t o);
        int cyc, wcnt, since;
        logic acc, resp_done, done;
        o = '{default: 0};
        cyc = 0; wcnt = 0; since = 0; acc = 0; resp_done = 0; done = 0;
        @(negedge clk_i);
        valid_i = 1'b1; mem_access_i = mem; mem_we_i = we;
        alu_result_i = addr; write_data_i = wd; func3_i = f3;
        while (!done && cyc < 50) begin
            dc_ready_i = 1'b0; dc_rvalid_i = 1'b0; flush_i = 1'b0;
            if (cyc == flush_cyc) begin
                flush_i = 1'b1;
                valid_i = 1'b0;
            end
            if (dc_req_o && !acc) begin
                if (wcnt == rdy_dly) begin
                    dc_ready_i = 1'b1;
                    acc = 1'b1;
                    o.addr = dc_addr_o; o.we = dc_we_o; o.wdata = dc_wdata_o; o.wstrb = dc_wstrb_o;
                    if (!we && lat == 0) begin
                        dc_rvalid_i = 1'b1; dc_rdata_i = resp; resp_done = 1'b1;
                    end
                end else begin
                    wcnt++;
                end
            end else if (acc && !we && !resp_done) begin
                since++;
                if (since == lat) begin
                    dc_rvalid_i = 1'b1; dc_rdata_i = resp; resp_done = 1'b1;
                end
            end
            #1;
            if (stall_mem_o) o.stalls++;
            if (dc_req_o) o.reqs++;
            if (read_valid_o) begin o.rvalid = 1'b1; o.rdata = read_data_o; end
            if (misaligned_o) begin o.mis = 1'b1; o.cause = cause_o; end
            if (!stall_mem_o) done = 1'b1;
            cyc++;
            @(negedge clk_i);
        end
        if (!done) o.timeout = 1'b1;
        valid_i = 1'b0; mem_access_i = 1'b0; dc_ready_i = 1'b0; dc_rvalid_i = 1'b0; flush_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        valid_i = 1'b1; mem_access_i = 1'b1;
        #1;
        total++; if (stall_mem_o !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall_mem_o); end
        valid_i = 1'b0; mem_access_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++; if (dc_req_o !== 1'b0) begin bad++; $display("FAIL reset_dc_req: got %b want 0", dc_req_o); end
        total++; if (read_valid_o !== 1'b0) begin bad++; $display("FAIL reset_read_valid: got %b want 0", read_valid_o); end
        total++; if (read_data_o !== 64'h0) begin bad++; $display("FAIL reset_read_data: got %h want 0", read_data_o); end
        total++; if (dc_wstrb_o !== 8'h0 || dc_addr_o !== 64'h0) begin bad++; $display("FAIL reset_req_regs: got strb %h addr %h want 0", dc_wstrb_o, dc_addr_o); end
        total++; if (misaligned_o !== 1'b0 || cause_o !== 4'd0) begin bad++; $display("FAIL reset_trap: got %b/%0d want 0/0", misaligned_o, cause_o); end
    endtask

    task automatic test_nonmem();
        rec_t o;
        do_access(1'b0, 1'b0, 64'h1234, 64'h0, 3'd3, 64'h0, 0, 0, -1, o);
        total++; if (o.stalls != 0 || o.reqs != 0) begin bad++; $display("FAIL nonmem: got stalls %0d reqs %0d want 0 0", o.stalls, o.reqs); end
    endtask

    task automatic test_store(input string nm, input logic [63:0] addr, input logic [63:0] wd,
                              input logic [2:0] f3, input logic [63:0] want_addr,
                              input logic [7:0] want_strb, input logic [63:0] want_wdata);
        rec_t o, e;
        e = '{default: 0};
        e.addr = want_addr; e.we = 1'b1; e.wstrb = want_strb; e.wdata = want_wdata; e.stalls = 2;
        exp_q.push_back(e);
        do_access(1'b1, 1'b1, addr, wd, f3, 64'h0, 0, 0, -1, o);
        e = exp_q.pop_front();
        total++; if (o.addr !== e.addr || o.we !== e.we) begin bad++; $display("FAIL %s_addr: got %h we %b want %h we 1", nm, o.addr, o.we, e.addr); end
        total++; if (o.wstrb !== e.wstrb) begin bad++; $display("FAIL %s_wstrb: got %h want %h", nm, o.wstrb, e.wstrb); end
        total++; if (o.wdata !== e.wdata) begin bad++; $display("FAIL %s_wdata: got %h want %h", nm, o.wdata, e.wdata); end
        total++; if (o.stalls != e.stalls || o.timeout) begin bad++; $display("FAIL %s_stalls: got %0d want %0d", nm, o.stalls, e.stalls); end
    endtask

    task automatic test_load(input string nm, input logic [63:0] addr, input logic [2:0] f3,
                             input logic [63:0] resp, input int lat,
                             input logic [63:0] want_data, input int want_stalls);
        rec_t o, e;
        e = '{default: 0};
        e.rvalid = 1'b1; e.rdata = want_data; e.stalls = want_stalls;
        exp_q.push_back(e);
        do_access(1'b1, 1'b0, addr, 64'h0, f3, resp, 0, lat, -1, o);
        e = exp_q.pop_front();
        total++; if (o.rvalid !== 1'b1 || o.rdata !== e.rdata) begin bad++; $display("FAIL %s_data: got %h (valid %b) want %h", nm, o.rdata, o.rvalid, e.rdata); end
        total++; if (o.stalls != e.stalls || o.timeout) begin bad++; $display("FAIL %s_stalls: got %0d want %0d", nm, o.stalls, e.stalls); end
    endtask

    task automatic test_flush();
        rec_t o;
        do_access(1'b1, 1'b0, 64'h1008, 64'h0, 3'd3, 64'h55, 5, 0, 1, o);
        total++; if (o.reqs != 1) begin bad++; $display("FAIL flush_req_reqs: got %0d cycles with dc_req want 1", o.reqs); end
        total++; if (o.rvalid !== 1'b0 || o.timeout) begin bad++; $display("FAIL flush_req_rvalid: got %b want 0", o.rvalid); end
        do_access(1'b1, 1'b0, 64'h1010, 64'h0, 3'd3, 64'h77, 0, 3, 2, o);
        total++; if (o.rvalid !== 1'b0) begin bad++; $display("FAIL flush_wait_rvalid: got %b want 0", o.rvalid); end
        total++; if (o.stalls != 5 || o.timeout) begin bad++; $display("FAIL flush_wait_stalls: got %0d want 5", o.stalls); end
    endtask

    task automatic test_misalign();
        rec_t o;
        do_access(1'b1, 1'b0, 64'h1001, 64'h0, 3'd1, 64'h0000_0000_0000_8001, 0, 0, -1, o);
`ifdef MISALIGN_TRAP_EN
        total++; if (o.reqs != 0 || o.stalls != 1) begin bad++; $display("FAIL mis_ld_flow: got reqs %0d stalls %0d want 0 1", o.reqs, o.stalls); end
        total++; if (o.mis !== 1'b1 || o.cause !== 4'd4 || o.rvalid !== 1'b0) begin bad++; $display("FAIL mis_ld_cause: got %b/%0d rv %b want 1/4 rv 0", o.mis, o.cause, o.rvalid); end
        do_access(1'b1, 1'b1, 64'h1003, 64'hBEEF, 3'd1, 64'h0, 0, 0, -1, o);
        total++; if (o.reqs != 0 || o.mis !== 1'b1 || o.cause !== 4'd6) begin bad++; $display("FAIL mis_st_cause: got reqs %0d %b/%0d want 0 1/6", o.reqs, o.mis, o.cause); end
`else
        total++; if (o.addr !== 64'h1000 || o.wstrb !== 8'h03) begin bad++; $display("FAIL mis_ld_lanes: got %h %h want 1000 03", o.addr, o.wstrb); end
        total++; if (o.rdata !== 64'hFFFF_FFFF_FFFF_8001 || o.mis !== 1'b0) begin bad++; $display("FAIL mis_ld_data: got %h mis %b want ffffffffffff8001 0", o.rdata, o.mis); end
        do_access(1'b1, 1'b1, 64'h1003, 64'hBEEF, 3'd1, 64'h0, 0, 0, -1, o);
        total++; if (o.wstrb !== 8'h0C || o.wdata !== 64'hBEEF_0000) begin bad++; $display("FAIL mis_st_lanes: got %h %h want 0c beef0000", o.wstrb, o.wdata); end
`endif
    endtask

    task automatic test_back_to_back();
        rec_t o, e;
        logic [2:0]  f3_tab[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        logic [63:0] addr, wd, resp;
        logic [2:0]  f3;
        logic        we;
        int          rdy, lat;
        for (int i = 0; i < 14; i++) begin
            f3 = f3_tab[i % 7];
            we = (i % 3 == 0) && (f3 < 3'd4);
            addr = 64'h4000 + 64'(i * 16) + 64'($urandom_range(0, 7) & ~(size_of(f3) - 1));
            wd = {$urandom, $urandom};
            resp = {$urandom, $urandom};
            rdy = $urandom_range(0, 2);
            lat = $urandom_range(0, 3);
            e = model_req(we, addr, wd, f3);
            e.rvalid = !we;
            e.rdata = we ? 64'h0 : model_load(addr, resp, f3);
            e.stalls = 2 + rdy + (we ? 0 : lat);
            e.reqs = rdy + 1;
            exp_q.push_back(e);
            do_access(1'b1, we, addr, wd, f3, resp, rdy, lat, -1, o);
            e = exp_q.pop_front();
            total++;
            if (o.addr !== e.addr || o.wstrb !== e.wstrb || (we && o.wdata !== e.wdata) ||
                o.rvalid !== e.rvalid || (!we && o.rdata !== e.rdata) ||
                o.stalls != e.stalls || o.reqs != e.reqs || o.timeout) begin
                bad++;
                $display("FAIL b2b_%0d: got a=%h s=%h w=%h rv=%b d=%h st=%0d rq=%0d want a=%h s=%h w=%h rv=%b d=%h st=%0d rq=%0d",
                         i, o.addr, o.wstrb, o.wdata, o.rvalid, o.rdata, o.stalls, o.reqs,
                         e.addr, e.wstrb, e.wdata, e.rvalid, e.rdata, e.stalls, e.reqs);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk_i);
        valid_i = 1'b1; mem_access_i = 1'b1; mem_we_i = 1'b0; alu_result_i = 64'h2000; func3_i = 3'd3;
        @(negedge clk_i);
        #1;
        total++; if (dc_req_o !== 1'b1) begin bad++; $display("FAIL rstmid_req: got %b want 1", dc_req_o); end
        rst_i = 1'b1; valid_i = 1'b0; mem_access_i = 1'b0;
        #1;
        total++; if (dc_req_o !== 1'b0 || stall_mem_o !== 1'b0) begin bad++; $display("FAIL rstmid_drop: got req %b stall %b want 0 0", dc_req_o, stall_mem_o); end
        @(negedge clk_i);
        rst_i = 1'b0; dc_rvalid_i = 1'b1; dc_rdata_i = 64'hDEAD_BEEF_0BAD_F00D;
        @(negedge clk_i);
        dc_rvalid_i = 1'b0;
        #1;
        total++; if (read_valid_o !== 1'b0 || read_data_o !== 64'h0 || dc_req_o !== 1'b0) begin bad++; $display("FAIL rstmid_late: got rv %b data %h req %b want 0 0 0", read_valid_o, read_data_o, dc_req_o); end
    endtask

    initial begin
        test_reset();
        test_nonmem();
        test_store("sd", 64'h1000, 64'h1122_3344_5566_7788, 3'd3, 64'h1000, 8'hFF, 64'h1122_3344_5566_7788);
        test_store("sb", 64'h1003, 64'h1234_5678_9ABC_DEAB, 3'd0, 64'h1000, 8'h08, 64'h0000_0000_AB00_0000);
        test_load("lb", 64'h1005, 3'd0, 64'h0000_8000_0000_0000, 3, 64'hFFFF_FFFF_FFFF_FF80, 5);
        test_load("lbu", 64'h1005, 3'd4, 64'h0000_8000_0000_0000, 3, 64'h0000_0000_0000_0080, 5);
        test_load("lw_hit", 64'h1004, 3'd2, 64'h8765_4321_0000_0000, 0, 64'hFFFF_FFFF_8765_4321, 2);
        test_load("lwu_hit", 64'h1004, 3'd6, 64'h8765_4321_0000_0000, 0, 64'h0000_0000_8765_4321, 2);
        test_flush();
        test_misalign();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
